// File: rtl/video_timing_monitor.sv
// Measures video timing (line/frame totals, active sizes, sync polarity) from
// ce_pix-qualified sync/blank inputs and reports lock once STABLE_FRAMES frames agree.
module video_timing_monitor #(
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned CW            = 12
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          hs,
  input  logic          vs,
  input  logic          hblank,
  input  logic          vblank,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic          hs_pol,
  output logic          vs_pol,
  output logic          locked,
  output logic          frame_pulse,
  output logic          mode_change
);

  typedef enum logic [1:0] {IDLE, MEASURE, CHECK, LOCKED} state_t;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    STABLE_N = 4'(STABLE_FRAMES);

  state_t        state, state_next;

  logic          hblank_q, vblank_q;
  logic          line_start, frame_start;

  logic [CW-1:0] pix_cnt, act_cnt, line_cnt, vact_cnt;
  logic [CW-1:0] ref_h, ref_a;
  logic          have_ref, incons, line_open;
  logic          fhs_pol, fvs_pol;

  logic [CW-1:0] st_h, st_a, st_v, st_va;
  logic          st_hp, st_vp;
  logic [3:0]    match_cnt, match_next, match_inc;

  logic          pix_sat, line_done, line_mism, frame_bad, cand_same;
  logic          store_set, mc_next;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign line_start  = ce_pix & hblank_q & ~hblank;
  assign frame_start = ce_pix & vblank_q & ~vblank;

  // The line closing on a frame-start cycle still belongs to the frame that is ending,
  // so its mismatch is folded into frame_bad before the per-frame state is cleared.
  assign pix_sat   = (pix_cnt == CNT_MAX);
  assign line_done = line_start & line_open;
  assign line_mism = line_done & have_ref & ((pix_cnt != ref_h) | (act_cnt != ref_a));
  assign frame_bad = incons | line_mism;
  assign cand_same = (pix_cnt == st_h) & (act_cnt == st_a) & (line_cnt == st_v) &
                     (vact_cnt == st_va) & (fhs_pol == st_hp) & (fvs_pol == st_vp);
  assign match_inc = match_cnt + 4'd1;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hblank_q  <= 1'b0;
      vblank_q  <= 1'b0;
      pix_cnt   <= '0;
      act_cnt   <= '0;
      line_cnt  <= '0;
      vact_cnt  <= '0;
      ref_h     <= '0;
      ref_a     <= '0;
      have_ref  <= 1'b0;
      incons    <= 1'b0;
      line_open <= 1'b0;
      fhs_pol   <= 1'b0;
      fvs_pol   <= 1'b0;
    end else begin
      if (ce_pix) begin
        hblank_q <= hblank;
        vblank_q <= vblank;
      end

      if (line_start) begin
        pix_cnt <= CNT_ONE;
        act_cnt <= CNT_ONE;
      end else if (ce_pix) begin
        pix_cnt <= sat_inc(pix_cnt);
        if (!hblank) act_cnt <= sat_inc(act_cnt);
      end

      if (line_start)   line_open <= 1'b1;
      else if (pix_sat) line_open <= 1'b0;

      if (frame_start) begin
        line_cnt <= line_start ? CNT_ONE : '0;
        vact_cnt <= line_start ? CNT_ONE : '0;
      end else if (line_start) begin
        line_cnt <= sat_inc(line_cnt);
        if (!vblank) vact_cnt <= sat_inc(vact_cnt);
      end

      if (frame_start) begin
        have_ref <= 1'b0;
        incons   <= 1'b0;
        fhs_pol  <= ~hs;
        fvs_pol  <= ~vs;
      end else if (line_done) begin
        if (!have_ref) begin
          ref_h    <= pix_cnt;
          ref_a    <= act_cnt;
          have_ref <= 1'b1;
        end
        incons <= frame_bad;
      end
    end
  end

  always_comb begin
    state_next = state;
    match_next = match_cnt;
    store_set  = 1'b0;
    mc_next    = 1'b0;
    if (state != IDLE && pix_sat) begin
      state_next = IDLE;
      match_next = '0;
      mc_next    = (state == LOCKED);
    end else if (frame_start) begin
      unique case (state)
        IDLE: begin
          state_next = MEASURE;
          match_next = '0;
        end
        MEASURE: begin
          if (!frame_bad) begin
            store_set  = 1'b1;
            match_next = 4'd1;
            state_next = (STABLE_N <= 4'd1) ? LOCKED : CHECK;
          end
        end
        CHECK: begin
          if (!frame_bad && cand_same) begin
            match_next = match_inc;
            if (match_inc >= STABLE_N) state_next = LOCKED;
          end else begin
            store_set  = 1'b1;
            match_next = 4'd1;
          end
        end
        LOCKED: begin
          if (frame_bad || !cand_same) begin
            state_next = MEASURE;
            match_next = '0;
            mc_next    = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      match_cnt   <= '0;
      st_h        <= '0;
      st_a        <= '0;
      st_v        <= '0;
      st_va       <= '0;
      st_hp       <= 1'b0;
      st_vp       <= 1'b0;
      h_total     <= '0;
      h_active    <= '0;
      v_total     <= '0;
      v_active    <= '0;
      hs_pol      <= 1'b0;
      vs_pol      <= 1'b0;
      locked      <= 1'b0;
      frame_pulse <= 1'b0;
      mode_change <= 1'b0;
    end else begin
      state       <= state_next;
      match_cnt   <= match_next;
      locked      <= (state_next == LOCKED);
      frame_pulse <= frame_start;
      mode_change <= mc_next;
      if (store_set) begin
        st_h  <= pix_cnt;
        st_a  <= act_cnt;
        st_v  <= line_cnt;
        st_va <= vact_cnt;
        st_hp <= fhs_pol;
        st_vp <= fvs_pol;
      end
      // Entry to LOCKED implies the candidate equals the stored set (or is being stored now).
      if (state_next == LOCKED && state != LOCKED) begin
        h_total  <= pix_cnt;
        h_active <= act_cnt;
        v_total  <= line_cnt;
        v_active <= vact_cnt;
        hs_pol   <= fhs_pol;
        vs_pol   <= fvs_pol;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_monitor.sv
// Scoreboard bench: each driven frame start queues its expected status; a monitor
// pops and compares on every frame_pulse.
module tb_video_timing_monitor;

  localparam int unsigned CW = 12;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ce_pix, hs, vs, hblank, vblank;
  logic [CW-1:0] h_total, h_active, v_total, v_active;
  logic          hs_pol, vs_pol, locked, frame_pulse, mode_change;

  video_timing_monitor #(.STABLE_FRAMES(2), .CW(CW)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
    .hs(hs), .vs(vs), .hblank(hblank), .vblank(vblank),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .hs_pol(hs_pol), .vs_pol(vs_pol), .locked(locked),
    .frame_pulse(frame_pulse), .mode_change(mode_change)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          idx;
    logic        lk, mc;
    logic [11:0] ht, ha, vt, va;
    logic        hp, vp;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   mc_count   = 0;
  int   ce_div     = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int idx, input logic lk, input logic mc,
                              input int ht, input int ha, input int vt, input int va,
                              input logic hp, input logic vp);
    exp_t e;
    e.idx = idx; e.lk = lk; e.mc = mc;
    e.ht = 12'(ht); e.ha = 12'(ha); e.vt = 12'(vt); e.va = 12'(va);
    e.hp = hp; e.vp = vp;
    return e;
  endfunction

  always @(negedge clk_sys) begin
    if (!reset) begin
      if (mode_change) mc_count++;
      if (frame_pulse) begin
        chk("queue_nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk($sformatf("locked f%0d", e.idx),      locked,      e.lk);
          chk($sformatf("mode_change f%0d", e.idx), mode_change, e.mc);
          chk($sformatf("h_total f%0d", e.idx),     h_total,     e.ht);
          chk($sformatf("h_active f%0d", e.idx),    h_active,    e.ha);
          chk($sformatf("v_total f%0d", e.idx),     v_total,     e.vt);
          chk($sformatf("v_active f%0d", e.idx),    v_active,    e.va);
          chk($sformatf("hs_pol f%0d", e.idx),      hs_pol,      e.hp);
          chk($sformatf("vs_pol f%0d", e.idx),      vs_pol,      e.vp);
        end
      end
    end
  end

  task automatic drive_pix(input logic hb, input logic vb, input logic h, input logic v);
    ce_pix = 1'b1; hblank = hb; vblank = vb; hs = h; vs = v;
    @(posedge clk_sys); #1;
    for (int i = 1; i < ce_div; i++) begin
      ce_pix = 1'b0;
      {hblank, vblank, hs, vs} = 4'($urandom);
      @(posedge clk_sys); #1;
    end
  endtask

  task automatic preamble(input logic inv);
    for (int i = 0; i < 4; i++) drive_pix(1'b1, 1'b1, ~inv, ~inv);
  endtask

  task automatic run_frame(input int ht, input int ha, input int vt, input int va,
                           input int bad_line, input int stop_line, input logic inv,
                           input exp_t e);
    int len;
    exp_q.push_back(e);
    for (int y = 0; y < vt; y++) begin
      len = (y == bad_line) ? ht + 1 : ht;
      for (int x = 0; x < len; x++) begin
        if (y == stop_line && x == 10) return;
        drive_pix(x >= ha, y >= va, inv ^ !(x >= ha + 2 && x < ha + 6), inv ^ !(y == va + 1));
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; ce_pix = 1'b0; hs = 1'b1; vs = 1'b1; hblank = 1'b1; vblank = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int mc_before;
    reset = 1'b1; ce_pix = 1'b0; hs = 1'b1; vs = 1'b1; hblank = 1'b1; vblank = 1'b1;
    #1;
    chk("reset locked", locked, 0);
    chk("reset h_total", h_total, 0);
    do_reset();

    // Pixel enable every 4th cycle with garbage on the idle cycles.
    ce_div = 4;
    preamble(1'b0);
    run_frame(40, 32, 26, 24, -1, -1, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    run_frame(40, 32, 26, 24, -1, -1, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0));
    run_frame(40, 32, 26, 24, -1, -1, 1'b0, mk(3, 1, 0, 40, 32, 26, 24, 0, 0));
    run_frame(40, 32, 26, 24, -1, -1, 1'b0, mk(4, 1, 0, 40, 32, 26, 24, 0, 0));

    // Mode switch to a wider line.
    ce_div = 1;
    run_frame(42, 32, 26, 24, -1, -1, 1'b0, mk(5, 1, 0, 40, 32, 26, 24, 0, 0));
    run_frame(42, 32, 26, 24, -1, -1, 1'b0, mk(6, 0, 1, 40, 32, 26, 24, 0, 0));
    run_frame(42, 32, 26, 24, -1, -1, 1'b0, mk(7, 0, 0, 40, 32, 26, 24, 0, 0));
    run_frame(42, 32, 26, 24, -1, -1, 1'b0, mk(8, 1, 0, 42, 32, 26, 24, 0, 0));

    // One over-long line makes the frame inconsistent.
    run_frame(42, 32, 26, 24,  5, -1, 1'b0, mk(9,  1, 0, 42, 32, 26, 24, 0, 0));
    run_frame(42, 32, 26, 24, -1, -1, 1'b0, mk(10, 0, 1, 42, 32, 26, 24, 0, 0));
    run_frame(42, 32, 26, 24, -1, -1, 1'b0, mk(11, 0, 0, 42, 32, 26, 24, 0, 0));
    run_frame(42, 32, 26, 24, -1, -1, 1'b0, mk(12, 1, 0, 42, 32, 26, 24, 0, 0));

    // Stuck hblank saturates the pixel counter.
    run_frame(42, 32, 26, 24, -1,  3, 1'b0, mk(13, 1, 0, 42, 32, 26, 24, 0, 0));
    mc_before = mc_count;
    for (int i = 0; i < 5000; i++) drive_pix(1'b1, 1'b0, 1'b1, 1'b1);
    chk("sat mode_change pulses", 32'(mc_count - mc_before), 1);
    chk("sat locked", locked, 0);
    chk("sat h_total hold", h_total, 42);
    chk("sat v_active hold", v_active, 24);
    chk("sat pix_cnt clamp", dut.pix_cnt, 4095);
    preamble(1'b0);
    run_frame(40, 32, 26, 24, -1, -1, 1'b0, mk(14, 0, 0, 42, 32, 26, 24, 0, 0));
    run_frame(40, 32, 26, 24, -1, -1, 1'b0, mk(15, 0, 0, 42, 32, 26, 24, 0, 0));
    run_frame(40, 32, 26, 24, -1, -1, 1'b0, mk(16, 1, 0, 40, 32, 26, 24, 0, 0));

    // Reset mid-line while locked, then relock with active-high syncs.
    run_frame(40, 32, 26, 24, -1,  3, 1'b0, mk(17, 1, 0, 40, 32, 26, 24, 0, 0));
    chk("pre-reset locked", locked, 1);
    reset = 1'b1;
    #1;
    chk("rst locked", locked, 0);
    chk("rst h_total", h_total, 0);
    chk("rst h_active", h_active, 0);
    chk("rst v_total", v_total, 0);
    chk("rst v_active", v_active, 0);
    chk("rst frame_pulse", frame_pulse, 0);
    chk("rst mode_change", mode_change, 0);
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    preamble(1'b1);
    run_frame(40, 32, 26, 24, -1, -1, 1'b1, mk(18, 0, 0, 0, 0, 0, 0, 0, 0));
    run_frame(40, 32, 26, 24, -1, -1, 1'b1, mk(19, 0, 0, 0, 0, 0, 0, 0, 0));
    run_frame(40, 32, 26, 24, -1, -1, 1'b1, mk(20, 1, 0, 40, 32, 26, 24, 1, 1));
    run_frame(40, 32, 26, 24, -1, -1, 1'b1, mk(21, 1, 0, 40, 32, 26, 24, 1, 1));

    repeat (4) @(posedge clk_sys);
    chk("leftover expectations", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/video_timing_monitor.md
VIDEO_TIMING_MONITOR -- requirements
Module: video_timing_monitor

Interface
REQ-001 SHALL have parameter STABLE_FRAMES, default 2, number of consecutive identical frames required before lock (legal range 1..15).
REQ-002 SHALL have parameter CW, default 12, width of all measurement counters and outputs.
REQ-003 clk_sys  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ce_pix  input  1  pixel enable; video inputs SHALL be sampled only on cycles with ce_pix=1.
REQ-006 hs, vs  input  1 each  horizontal and vertical sync, either polarity.
REQ-007 hblank, vblank  input  1 each  active-high blanking; active pixel = ~(hblank|vblank).
REQ-008 h_total, h_active, v_total, v_active  output  CW each  measured line length and active width in pixels; frame height and active height in lines.
REQ-009 hs_pol, vs_pol  output  1 each  1 = active-high sync.
REQ-010 locked  output  1  measurements valid and stable.
REQ-011 frame_pulse  output  1  one-clk_sys pulse at each frame start, i.e. each vblank falling edge.
REQ-012 mode_change  output  1  one-clk_sys pulse when lock is lost.

Function
REQ-013 Edges SHALL be detected against the previous ce_pix-qualified sample; input levels on ce_pix=0 cycles SHALL be ignored.
REQ-014 Line start = hblank 1->0; frame start = vblank 1->0; both on the same ce cycle SHALL count as line 0 of the new frame.
REQ-015 Pixel counter SHALL count ce cycles from line start; h_total candidate = count at the next line start (the start pixel counted once).
REQ-016 h_active candidate = number of ce cycles with hblank=0 within the line.
REQ-017 Line counter SHALL count line starts from frame start; v_total candidate = count at the next frame start; v_active candidate = lines whose start has vblank=0.
REQ-018 hs_pol candidate = ~hs and vs_pol candidate = ~vs, sampled at frame start.
REQ-019 A frame SHALL be marked inconsistent if any two complete lines in it give differing h_total or h_active.
REQ-020 All counters SHALL saturate at 2^CW-1; saturation of the pixel counter (no line start for 2^CW-1 ce cycles) SHALL force state IDLE.
REQ-021 FSM states: IDLE, MEASURE, CHECK, LOCKED.
REQ-022 IDLE -> MEASURE on the first frame start; counters cleared.
REQ-023 MEASURE -> CHECK on the next frame start; candidates stored; match_cnt=1 if frame consistent, else stay in MEASURE.
REQ-024 CHECK: at each frame start, a consistent frame equal to the stored set SHALL increment match_cnt, and any other frame SHALL store the new set with match_cnt=1; reaching STABLE_FRAMES -> LOCKED.
REQ-025 On entry to LOCKED, the outputs SHALL be loaded from the stored set in the same cycle that locked rises; the outputs SHALL hold while locked.
REQ-026 LOCKED: a frame that differs or is inconsistent, or pixel-counter saturation, SHALL cause a mode_change pulse, locked=0, and a transition to MEASURE (to IDLE on saturation); measurement outputs SHALL hold their last locked values.
REQ-027 STABLE_FRAMES=1 SHALL lock at the first frame start after MEASURE (CHECK exits in the same cycle).
REQ-028 locked SHALL rise exactly one clk_sys after the qualifying ce cycle; frame_pulse SHALL have the same one-cycle latency.

Reset
REQ-029 Asserting reset SHALL immediately force state IDLE, clear all counters and edge history, and set every output to 0, including during an in-progress frame.
REQ-030 After reset deasserts, the first vblank falling edge SHALL only start measurement; no lock SHALL occur before STABLE_FRAMES+1 frame starts.

Verification
REQ-031 400x262 total, 320x240 active, hs/vs active-low, ce_pix=1 every cycle -> locked=1 after the 3rd frame start; outputs 400/320/262/240; hs_pol=vs_pol=0.
REQ-032 Same timing with ce_pix every 4th cycle and inputs toggled on ce=0 cycles -> identical values; toggles on ce=0 cycles ignored.
REQ-033 While locked, switch to 424x262 -> one mode_change pulse at the next frame start; locked=0; relock with h_total=424 after 2 more matching frames.
REQ-034 Hold hblank=1 for 5000 ce cycles while locked -> mode_change pulse, IDLE, all counts saturate without wrap.
REQ-035 One line of 401 pixels inside a 400-pixel frame -> frame inconsistent; no lock that frame.
REQ-036 Assert reset mid-line while locked -> all outputs 0 in the same cycle; relock takes 3 frame starts after release.
